latch_write_ctrl: RTL
=====================

// Module: latch_write_ctrl
//
// PURPOSE
//  - Clocked write-side controller for a level-sensitive D latch (ports d/en/clear).
//  - Accepts write/clear requests on a valid/ready handshake.
//  - Sequences lat_d setup, the lat_en pulse and lat_d hold with programmable cycle counts.
//  - Sits between synchronous logic and latch-based storage, so latch timing is guaranteed by construction.
//
// PARAMETERS
//  WIDTH      8  data width of req_data / lat_d
//  SETUP_CYC  1  cycles lat_d is stable before lat_en rises (0 = skip SETUP)
//  PULSE_CYC  2  cycles lat_en (or lat_rstn low) is asserted; must be >= 1
//  HOLD_CYC   1  cycles lat_d is held after lat_en falls (0 = skip HOLD)
//
// PORTS
//  clk        in   1      rising-edge clock
//  rstn       in   1      reset, synchronous, active-low
//  req_valid  in   1      request present
//  req_ready  out  1      controller can accept (high only in IDLE)
//  req_clr    in   1      1 = clear request, 0 = write request (sampled on accept)
//  req_data   in   WIDTH  write data (sampled on accept)
//  lat_d      out  WIDTH  latch data input, registered
//  lat_en     out  1      latch enable, registered
//  lat_rstn   out  1      latch clear, active-low, registered
//  busy       out  1      high in any state other than IDLE
//  done       out  1      one-cycle pulse when a request completes
//
// BEHAVIOUR
//  - Reset (rstn low at an edge):
//    - State -> IDLE, and lat_d=0, lat_en=0, done=0, busy=0, req_ready=0.
//    - lat_rstn=0 while reset is held, so the latch is cleared.
//    - First edge with rstn high: lat_rstn=1 and req_ready=1.
//  - Reset mid-operation aborts the sequence at that edge; the request is lost and no done is pulsed.
//  - Accept: req_valid && req_ready at an edge; request fields are captured at that edge.
//  - FSM: IDLE -> SETUP -> PULSE -> HOLD -> IDLE; clear requests use IDLE -> CLEAR -> IDLE.
//    - SETUP: lat_d = captured data, lat_en=0, for SETUP_CYC cycles.
//    - PULSE: lat_en=1 for exactly PULSE_CYC cycles; lat_d unchanged.
//    - HOLD: lat_en=0, lat_d unchanged, for HOLD_CYC cycles.
//    - CLEAR: lat_rstn=0 for PULSE_CYC cycles; lat_en=0; lat_d unchanged.
//    - A zero-length phase is skipped (SETUP_CYC=0 goes straight to PULSE; HOLD_CYC=0 goes to IDLE).
//  - done:
//    - Pulses in the first IDLE cycle after HOLD or CLEAR; req_ready=1 in that same cycle.
//    - Write latency, accept edge -> done: SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
//    - Clear latency, accept edge -> done: PULSE_CYC+1 cycles.
//  - Back-to-back: a request held valid is accepted on the done cycle; no extra bubble.
//  - Invariants:
//    - lat_en and !lat_rstn are never high together.
//    - lat_d never changes while lat_en=1.
//  - Phase counter:
//    - Width CNT_W = $clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1).
//    - Loaded with (phase length - 1) on phase entry; counts down; the phase ends at 0. No wrap.
//
// CONFIGURATION
//  - Optional feature: readback check, enabled by macro LATCH_WR_READBACK_EN.
//  - Defined:
//    - Adds input lat_q[WIDTH] and output rd_err[1].
//    - Comparison is made in the last HOLD cycle, or the last CLEAR cycle for clears.
//    - Write: lat_q is compared against lat_d. Clear: lat_q is compared against 0.
//    - rd_err is valid only with done; it is 1 on mismatch and 0 otherwise. Reset value is 0.
//  - Undefined: the lat_q and rd_err ports do not exist and there is no compare logic.
//
// STRUCTURE
//  - Package latch_wr_pkg:
//    - typedef enum state_t {IDLE, SETUP, PULSE, HOLD, CLEAR}.
//    - function cnt_w() returning CNT_W.
//  - One sub-module: latch_wr_timer.
//    - Loadable down-counter: load, value, zero flag.
//    - One instance, shared by all phases.
//  - All outputs come from flops; there are no combinational paths from req_* to lat_*.
//
// TESTING (defaults WIDTH=8, SETUP=1, PULSE=2, HOLD=1; cycle 0 = accept edge)
//  - Write 8'hA5:
//    - lat_d=A5 from cycle 1.
//    - lat_en=1 in cycles 2-3 only.
//    - done in cycle 5; busy in cycles 1-4.
//  - Clear request: lat_rstn=0 in cycles 1-2, lat_en stays 0, done in cycle 3.
//  - Back-to-back writes 8'h01 then 8'hFE, valid held high:
//    - Second request accepted on the done cycle.
//    - lat_d stable during each lat_en pulse.
//  - rstn low during PULSE:
//    - Next edge: lat_en=0, lat_d=0, lat_rstn=0, no done.
//    - After release: req_ready=1 one cycle later.
//  - SETUP_CYC=0, HOLD_CYC=0: lat_en in cycles 1-2, done in cycle 3.
//  - With LATCH_WR_READBACK_EN:
//    - lat_q tied to lat_d gives rd_err=0.
//    - lat_q forced to 8'h00 on a write of 8'h3C gives rd_err=1 with done.

Source files
------------

// File: rtl/latch_wr_pkg.sv
// Shared types and helpers for the latch write controller.
package latch_wr_pkg;

  // Controller phases: write = SETUP/PULSE/HOLD, clear = CLEAR.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    CLEAR
  } state_t;

  // Phase counter width: enough bits to hold the longest (length - 1).
  function automatic int cnt_w(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
    int m;
    m = pulse_cyc;
    if (setup_cyc > m) m = setup_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/latch_wr_timer.sv
// Loadable down-counter shared by all controller phases.
// A load sets the count; otherwise it decrements and parks at zero.
module latch_wr_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority, otherwise count down without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/latch_write_ctrl.sv
// Write-side controller for a level-sensitive D latch. Sequences data
// setup, the enable pulse and data hold (or a clear pulse) from a
// valid/ready request. All outputs are registered.
// Optional readback check: define LATCH_WR_READBACK_EN to add lat_q/rd_err.
module latch_write_ctrl
  import latch_wr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_clr,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  output logic             lat_rstn,
  output logic             busy,
  output logic             done
`ifdef LATCH_WR_READBACK_EN
  ,
  input  logic [WIDTH-1:0] lat_q,
  output logic             rd_err
`endif
);

  localparam int CNT_W = cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  // Timer load values are (phase length - 1); skipped phases never load.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'((PULSE_CYC > 0) ? PULSE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] lat_d_q;
  logic [WIDTH-1:0] lat_d_d;
  logic             lat_en_q;
  logic             lat_en_d;
  logic             lat_rstn_q;
  logic             lat_rstn_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic             req_ready_q;
  logic             req_ready_d;

  logic             accept;
  logic             finish;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  assign accept = req_valid && req_ready_q;

  latch_wr_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

  // Phase sequencing and timer loading; a phase ends when the timer reads zero.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = PULSE_LD;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
          if (req_clr) begin
            state_d = CLEAR;
            tmr_val = PULSE_LD;
          end else if (SETUP_CYC > 0) begin
            state_d = SETUP;
            tmr_val = SETUP_LD;
          end else begin
            state_d = PULSE;
            tmr_val = PULSE_LD;
          end
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          state_d  = PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          if (HOLD_CYC > 0) begin
            state_d  = HOLD;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (tmr_zero) state_d = IDLE;
      end
      CLEAR: begin
        if (tmr_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values derived from the next state, so every output is a flop.
  always_comb begin
    finish      = (state_q != IDLE) && (state_d == IDLE);
    lat_en_d    = (state_d == PULSE);
    lat_rstn_d  = (state_d != CLEAR);
    busy_d      = (state_d != IDLE);
    req_ready_d = (state_d == IDLE);
    done_d      = finish;
    lat_d_d     = lat_d_q;
    if (accept && !req_clr) lat_d_d = req_data;
  end

  // Controller state and registered latch-side outputs; reset clears the latch.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      lat_d_q     <= '0;
      lat_en_q    <= 1'b0;
      lat_rstn_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_d_q     <= lat_d_d;
      lat_en_q    <= lat_en_d;
      lat_rstn_q  <= lat_rstn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign lat_d     = lat_d_q;
  assign lat_en    = lat_en_q;
  assign lat_rstn  = lat_rstn_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign req_ready = req_ready_q;

`ifdef LATCH_WR_READBACK_EN
  logic rd_err_q;
  logic rd_err_d;

  // Compare the latch contents in the final cycle of a request; result lands with done.
  always_comb begin
    rd_err_d = 1'b0;
    if (finish) begin
      if (state_q == CLEAR) rd_err_d = (lat_q != '0);
      else                  rd_err_d = (lat_q != lat_d_q);
    end
  end

  // Readback error flag register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_err_q <= 1'b0;
    end else begin
      rd_err_q <= rd_err_d;
    end
  end

  assign rd_err = rd_err_q;
`endif

endmodule
